// File: rtl/axi_line_master.sv
// AXI4 line master: turns one cache-line request into a single INCR burst.
// Refill uses AR/R, writeback uses AW/W/B; one transaction in flight at a time.
module axi_line_master #(
  parameter int unsigned BEATS  = 4,
  parameter logic [3:0]  AXI_ID = 4'd0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // Line request / response port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [64*BEATS-1:0]   req_wline,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [64*BEATS-1:0]   resp_rline,
  // AR channel
  output logic                  arvalid,
  input  logic                  arready,
  output logic [31:0]           araddr,
  output logic [3:0]            arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  // R channel
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [63:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [3:0]            rid,
  // AW channel
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           awaddr,
  output logic [3:0]            awid,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  // W channel
  output logic                  wvalid,
  input  logic                  wready,
  output logic [63:0]           wdata,
  output logic [7:0]            wstrb,
  output logic                  wlast,
  output logic [3:0]            wid,
  // B channel
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  input  logic [3:0]            bid
);

  localparam int unsigned LineW   = 64 * BEATS;
  localparam int unsigned AlignW  = $clog2(8 * BEATS);
  localparam logic [31:0] AlignMask = ~((32'd1 << AlignW) - 32'd1);
  localparam logic [3:0]  LastCnt = 4'(BEATS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAw,
    StW,
    StB,
    StResp
  } state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             err_q;
  logic [31:0]      addr_q;
  // Holds the writeback line, or collects refill beats.
  logic [LineW-1:0] line_q;
  logic             arvalid_q;
  logic             rready_q;
  logic             awvalid_q;
  logic             wvalid_q;
  logic             bready_q;
  logic             resp_valid_q;
  logic             last_beat;

  // IDs are constant and responses arrive in order, so returned IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  assign last_beat = (cnt_q == LastCnt);

  // Main transaction FSM; every AXI valid/ready and the response pulse are registered here.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      line_q       <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q <= req_addr & AlignMask;
            line_q <= req_wline;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            if (req_we) begin
              awvalid_q <= 1'b1;
              state_q   <= StAw;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StAr;
            end
          end
        end
        StAr: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StR;
          end
        end
        StR: begin
          if (rvalid && rready_q) begin
            line_q[64*int'(cnt_q) +: 64] <= rdata;
            // rlast must line up exactly with the final beat we expect.
            if ((rresp != 2'b00) || (rlast != last_beat)) begin
              err_q <= 1'b1;
            end
            if (last_beat) begin
              cnt_q        <= '0;
              rready_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        StAw: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state_q   <= StW;
          end
        end
        StW: begin
          if (wready) begin
            if (last_beat) begin
              cnt_q    <= '0;
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= StB;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        StB: begin
          if (bvalid) begin
            if (bresp != 2'b00) begin
              err_q <= 1'b1;
            end
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Write data is a mux of registered line and counter, so it stays stable while stalled.
  always_comb begin
    wdata = line_q[64*int'(cnt_q) +: 64];
    wlast = last_beat;
  end

  // Request side: ready only in idle and never while reset is held.
  assign req_ready  = aresetn && (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_valid_q & err_q;
  assign resp_rline = line_q;

  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arid    = AXI_ID;
  assign arlen   = 8'(BEATS - 1);
  assign arsize  = 3'd3;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = rready_q;

  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awid    = AXI_ID;
  assign awlen   = 8'(BEATS - 1);
  assign awsize  = 3'd3;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wvalid = wvalid_q;
  assign wstrb  = 8'hFF;
  assign wid    = AXI_ID;
  assign bready = bready_q;

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master: refill, writeback, backpressure, error,
// mid-burst reset and back-to-back requests against a bench-side AXI slave.
module tb_axi_line_master;

  localparam int LW = 256;

  localparam logic [LW-1:0] RD1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [LW-1:0] RD2 = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                                   64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
  localparam logic [LW-1:0] RD3 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                   64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
  localparam logic [LW-1:0] WL1 = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                                   64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
  localparam logic [LW-1:0] WL2 = {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
                                   64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0};

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          req_valid, req_ready, req_we;
  logic [31:0]   req_addr;
  logic [LW-1:0] req_wline;
  logic          resp_valid, resp_err;
  logic [LW-1:0] resp_rline;
  logic          arvalid, arready;
  logic [31:0]   araddr;
  logic [3:0]    arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst, arlock;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          rvalid, rready, rlast;
  logic [63:0]   rdata;
  logic [1:0]    rresp;
  logic [3:0]    rid;
  logic          awvalid, awready;
  logic [31:0]   awaddr;
  logic [3:0]    awid;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst, awlock;
  logic [3:0]    awcache;
  logic [2:0]    awprot;
  logic          wvalid, wready, wlast;
  logic [63:0]   wdata;
  logic [7:0]    wstrb;
  logic [3:0]    wid;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic [3:0]    bid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int ovl = 0;
  int stab = 0;
  int acc_cyc = 0;
  int got_lat;
  logic          got_err;
  logic [LW-1:0] got_line;
  logic [LW-1:0] wmem;
  logic [3:0]    wlast_cap;
  logic [7:0]    wstrb_and;
  logic [31:0]   cap_addr;
  logic [7:0]    cap_len;
  logic [2:0]    cap_size;
  logic [1:0]    cap_burst;

  axi_line_master #(.BEATS(4), .AXI_ID(4'd0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wline(req_wline), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rline(resp_rline),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wid(wid), .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Response pulses and read/write channel overlap, sampled mid-cycle.
  always @(negedge aclk) begin
    if (resp_valid) resp_cnt <= resp_cnt + 1;
    if ((arvalid || rready) && (awvalid || wvalid || bready)) ovl <= ovl + 1;
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s observed no handshake within bound, expected handshake", tag);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_req(input logic we, input logic [31:0] a, input logic [LW-1:0] line);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wline = line;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) timeout("req_ready");
    tick();
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic ar_phase(input int dly);
    int n = 0;
    while (!arvalid && n < 50) begin tick(); n++; end
    if (!arvalid) timeout("arvalid");
    cap_addr  = araddr;
    cap_len   = arlen;
    cap_size  = arsize;
    cap_burst = arburst;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (!arvalid || araddr !== cap_addr || arlen !== cap_len) stab++;
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic r_phase(input logic [LW-1:0] line, input int err_beat, input int early_last,
                         input bit rnd);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      int dly = rnd ? int'($urandom_range(0, 3)) : 0;
      rvalid = 1'b0;
      repeat (dly) tick();
      rvalid = 1'b1;
      rdata  = line[64*k +: 64];
      rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      rlast  = (k == 3) || (k == early_last);
      while (!rready && n < 50) begin tick(); n++; end
      if (!rready) timeout("rready");
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic aw_phase(input int dly);
    int n = 0;
    while (!awvalid && n < 50) begin tick(); n++; end
    if (!awvalid) timeout("awvalid");
    cap_addr  = awaddr;
    cap_len   = awlen;
    cap_size  = awsize;
    cap_burst = awburst;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (!awvalid || awaddr !== cap_addr || wvalid) stab++;
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
  endtask

  task automatic w_phase(input bit rnd);
    wstrb_and = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      int dly = rnd ? int'($urandom_range(0, 3)) : 0;
      while (!wvalid && n < 50) begin tick(); n++; end
      if (!wvalid) timeout("wvalid");
      wmem[64*k +: 64] = wdata;
      wlast_cap[k]     = wlast;
      wstrb_and        = wstrb_and & wstrb;
      for (int i = 0; i < dly; i++) begin
        tick();
        if (!wvalid || wdata !== wmem[64*k +: 64] || wlast !== wlast_cap[k]) stab++;
      end
      wready = 1'b1;
      tick();
      wready = 1'b0;
    end
  endtask

  task automatic b_phase(input int dly, input logic [1:0] resp);
    int n = 0;
    while (!bready && n < 50) begin tick(); n++; end
    if (!bready) timeout("bready");
    for (int i = 0; i < dly; i++) begin
      tick();
      if (!bready) stab++;
    end
    bvalid = 1'b1;
    bresp  = resp;
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!resp_valid && n < 50) begin tick(); n++; end
    if (!resp_valid) timeout("resp_valid");
    got_err  = resp_err;
    got_line = resp_rline;
    got_lat  = cyc - acc_cyc;
    tick();
  endtask

  initial begin
    aresetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wline = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_req_ready_low", 256'(req_ready), 256'(0));
    chk("rst_outputs", 256'({arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}),
        256'(0));
    aresetn = 1'b1;
    #1;
    chk("post_rst_req_ready", 256'(req_ready), 256'(1));
    chk("ax_constants", 256'({arlock, arcache, arprot, awlock, awcache, awprot}), 256'(0));
    chk("ids_strb", 256'({arid, awid, wid, wstrb}), 256'(16'h00FF));

    // Stray rvalid/bvalid in idle are ignored
    rvalid = 1'b1; bvalid = 1'b1;
    #1;
    chk("stray_ready", 256'({rready, bready}), 256'(0));
    tick();
    chk("stray_idle", 256'({req_ready, arvalid, awvalid}), 256'(3'b100));
    rvalid = 1'b0; bvalid = 1'b0;

    // Refill, zero-wait slave
    send_req(1'b0, 32'h8000_0014, '0);
    ar_phase(0);
    chk("rd_araddr", 256'(cap_addr), 256'(32'h8000_0000));
    chk("rd_ar_fields", 256'({cap_len, cap_size, cap_burst}), 256'({8'd3, 3'd3, 2'b01}));
    r_phase(RD1, -1, -1, 1'b0);
    wait_resp();
    chk("rd_line", got_line, RD1);
    chk("rd_err", 256'(got_err), 256'(0));
    chk("rd_latency", 256'(got_lat), 256'(5));
    chk("rd_pulse_one_cycle", 256'(resp_valid), 256'(0));

    // Writeback, zero-wait slave
    send_req(1'b1, 32'h8000_1000, WL1);
    aw_phase(0);
    chk("wr_awaddr", 256'(cap_addr), 256'(32'h8000_1000));
    chk("wr_aw_fields", 256'({cap_len, cap_size, cap_burst}), 256'({8'd3, 3'd3, 2'b01}));
    w_phase(1'b0);
    chk("wr_mem", wmem, WL1);
    chk("wr_wlast", 256'(wlast_cap), 256'(4'b1000));
    chk("wr_wstrb", 256'(wstrb_and), 256'(8'hFF));
    b_phase(0, 2'b00);
    wait_resp();
    chk("wr_err", 256'(got_err), 256'(0));
    chk("wr_latency", 256'(got_lat), 256'(6));

    // Backpressured refill
    send_req(1'b0, 32'h8000_2038, '0);
    ar_phase(3);
    chk("bp_rd_araddr", 256'(cap_addr), 256'(32'h8000_2020));
    r_phase(RD2, -1, -1, 1'b1);
    wait_resp();
    chk("bp_rd_line", got_line, RD2);
    chk("bp_rd_err", 256'(got_err), 256'(0));

    // Backpressured writeback
    send_req(1'b1, 32'h8000_4010, WL2);
    aw_phase(2);
    chk("bp_wr_awaddr", 256'(cap_addr), 256'(32'h8000_4000));
    w_phase(1'b1);
    chk("bp_wr_mem", wmem, WL2);
    chk("bp_wr_wlast", 256'(wlast_cap), 256'(4'b1000));
    b_phase(3, 2'b00);
    wait_resp();
    chk("bp_wr_err", 256'(got_err), 256'(0));

    // SLVERR on beat 2: error flagged, burst still consumes 4 beats
    send_req(1'b0, 32'h8000_0000, '0);
    ar_phase(0);
    r_phase(RD1, 1, -1, 1'b0);
    wait_resp();
    chk("rresp_err", 256'(got_err), 256'(1));
    chk("rresp_err_latency", 256'(got_lat), 256'(5));

    // Early rlast on beat 3 of 4
    send_req(1'b0, 32'h8000_0000, '0);
    ar_phase(0);
    r_phase(RD1, -1, 2, 1'b0);
    wait_resp();
    chk("rlast_err", 256'(got_err), 256'(1));
    chk("rlast_err_latency", 256'(got_lat), 256'(5));

    // SLVERR on B
    send_req(1'b1, 32'h8000_1000, WL1);
    aw_phase(0);
    w_phase(1'b0);
    b_phase(1, 2'b10);
    wait_resp();
    chk("bresp_err", 256'(got_err), 256'(1));

    // Reset in the middle of R after one beat
    send_req(1'b0, 32'h8000_3000, '0);
    ar_phase(0);
    rvalid = 1'b1; rdata = 64'hDEAD_BEEF_DEAD_BEEF; rresp = 2'b00; rlast = 1'b0;
    tick();
    rvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("midr_rst_req_ready_low", 256'(req_ready), 256'(0));
    tick();
    aresetn = 1'b1;
    #1;
    chk("midr_outputs", 256'({arvalid, rready, awvalid, wvalid, bready, resp_valid}), 256'(0));
    chk("midr_req_ready", 256'(req_ready), 256'(1));
    send_req(1'b0, 32'h8000_3008, '0);
    ar_phase(0);
    chk("after_rst_araddr", 256'(cap_addr), 256'(32'h8000_3000));
    r_phase(RD3, -1, -1, 1'b0);
    wait_resp();
    chk("after_rst_line", got_line, RD3);
    chk("after_rst_err", 256'(got_err), 256'(0));

    // Back-to-back read then write with req_valid held high
    send_req(1'b0, 32'h8000_5000, '0);
    ar_phase(0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_6000; req_wline = WL1;
    r_phase(RD2, -1, -1, 1'b0);
    wait_resp();
    chk("b2b_rd_line", got_line, RD2);
    chk("b2b_idle_ready", 256'(req_ready), 256'(1));
    tick();
    acc_cyc   = cyc;
    req_valid = 1'b0;
    chk("b2b_awvalid", 256'({awvalid, awaddr}), 256'({1'b1, 32'h8000_6000}));
    aw_phase(0);
    w_phase(1'b0);
    b_phase(0, 2'b00);
    wait_resp();
    chk("b2b_wr_mem", wmem, WL1);
    chk("b2b_wr_latency", 256'(got_lat), 256'(6));

    // Global properties
    repeat (2) tick();
    chk("resp_pulse_count", 256'(resp_cnt), 256'(10));
    chk("stall_stability", 256'(stab), 256'(0));
    chk("rd_wr_overlap", 256'(ovl), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
